regfile_writeback_arbiter: RTL

Write-side front end for the 32-entry, 32-bit register file. It collects writeback results from two producers, the ALU and the load unit. Each producer has its own valid/ready handshake and its own small FIFO. The block serializes the results onto the register file's single write port (write enable, 5-bit register select, 32-bit data) using round-robin arbitration. It also publishes a per-register pending mask so issue logic can hold back dependent reads and write-after-write hazards.

---
 rtl/regfile_writeback_arbiter_pkg.sv | 24 ++
 rtl/regfile_writeback_arbiter_fifo.sv | 65 ++++++
 rtl/regfile_writeback_arbiter.sv | 118 +++++++++++
 3 files changed

// File: rtl/regfile_writeback_arbiter_pkg.sv
// Shared types for the register-file writeback path: index/data types,
// the queued writeback entry, and the arbitration source encoding.
package regfile_pkg;

  typedef logic [4:0]  reg_index_t;
  typedef logic [31:0] reg_data_t;

  typedef struct packed {
    reg_index_t select;
    reg_data_t  data;
  } writeback_entry_t;

  localparam reg_index_t REG_ZERO = 5'd0;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } wb_source_e;

  function automatic wb_source_e other_source(input wb_source_e src);
    return (src == SRC_ALU) ? SRC_MEM : SRC_ALU;
  endfunction

endpackage

// File: rtl/regfile_writeback_arbiter_fifo.sv
// In-order writeback queue with wrap-bit pointers; also exposes which slots
// hold live entries and their destination registers for hazard tracking.
module writeback_fifo
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         CLK,
  input  logic                         RESET_N,
  input  logic                         push,
  input  writeback_entry_t             push_entry,
  input  logic                         pop,
  output logic                         full,
  output logic                         empty,
  output writeback_entry_t             head,
  output logic       [DEPTH-1:0]       entry_valid,
  output reg_index_t [DEPTH-1:0]       entry_select
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  writeback_entry_t storage [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    count;
  logic [AW-1:0]    slot_offset;
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = wr_ptr - rd_ptr;
  assign head    = storage[rd_ptr[AW-1:0]];

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Payload storage needs no reset: pointers alone decide what is live.
  always_ff @(posedge CLK) begin
    if (do_push) storage[wr_ptr[AW-1:0]] <= push_entry;
  end

  // A slot is live when its distance from the read pointer is below the count.
  always_comb begin
    entry_valid  = '0;
    entry_select = '0;
    slot_offset  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      slot_offset     = AW'(i) - rd_ptr[AW-1:0];
      entry_valid[i]  = PW'(slot_offset) < count;
      entry_select[i] = storage[i].select;
    end
  end

endmodule

// File: rtl/regfile_writeback_arbiter.sv
// Register-file write port front end: two queued producers (ALU, load unit),
// round-robin serialization onto one write port, and a pending-write mask.
module regfile_writeback_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned fifo_depth    = 4,
  parameter int unsigned num_registers = 32
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic                     in_alu_valid,
  output logic                     out_alu_ready,
  input  logic [4:0]               in_alu_register_select,
  input  logic [31:0]              in_alu_data,
  input  logic                     in_mem_valid,
  output logic                     out_mem_ready,
  input  logic [4:0]               in_mem_register_select,
  input  logic [31:0]              in_mem_data,
  output logic                     out_write_enable,
  output logic [4:0]               out_write_register_select,
  output logic [31:0]              out_write_data,
  output logic [num_registers-1:0] out_pending
);

  logic                        alu_full, alu_empty, mem_full, mem_empty;
  logic                        alu_push, mem_push;
  logic                        grant_alu, grant_mem, pop_valid;
  writeback_entry_t            alu_entry, mem_entry;
  writeback_entry_t            alu_head, mem_head, pop_entry;
  logic       [fifo_depth-1:0] alu_valid_mask, mem_valid_mask;
  reg_index_t [fifo_depth-1:0] alu_selects, mem_selects;
  wb_source_e                  prio, prio_next;

  assign out_alu_ready = !alu_full;
  assign out_mem_ready = !mem_full;

  // x0 writes complete the handshake but are dropped before queueing.
  assign alu_push = in_alu_valid && out_alu_ready && (in_alu_register_select != REG_ZERO);
  assign mem_push = in_mem_valid && out_mem_ready && (in_mem_register_select != REG_ZERO);

  assign alu_entry = '{select: in_alu_register_select, data: in_alu_data};
  assign mem_entry = '{select: in_mem_register_select, data: in_mem_data};

  writeback_fifo #(.DEPTH(fifo_depth)) u_alu_fifo (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .push         (alu_push),
    .push_entry   (alu_entry),
    .pop          (grant_alu),
    .full         (alu_full),
    .empty        (alu_empty),
    .head         (alu_head),
    .entry_valid  (alu_valid_mask),
    .entry_select (alu_selects)
  );

  writeback_fifo #(.DEPTH(fifo_depth)) u_mem_fifo (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .push         (mem_push),
    .push_entry   (mem_entry),
    .pop          (grant_mem),
    .full         (mem_full),
    .empty        (mem_empty),
    .head         (mem_head),
    .entry_valid  (mem_valid_mask),
    .entry_select (mem_selects)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) prio <= SRC_ALU;
    else          prio <= prio_next;
  end

  // Priority only moves when both sources compete for the port.
  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    prio_next = prio;
    if (!alu_empty && !mem_empty) begin
      if (prio == SRC_ALU) grant_alu = 1'b1;
      else                 grant_mem = 1'b1;
      prio_next = other_source(prio);
    end else if (!alu_empty) begin
      grant_alu = 1'b1;
    end else if (!mem_empty) begin
      grant_mem = 1'b1;
    end
  end

  assign pop_valid = grant_alu || grant_mem;
  assign pop_entry = grant_mem ? mem_head : alu_head;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      out_write_enable          <= 1'b0;
      out_write_register_select <= REG_ZERO;
      out_write_data            <= '0;
    end else begin
      out_write_enable <= pop_valid;
      if (pop_valid) begin
        out_write_register_select <= pop_entry.select;
        out_write_data            <= pop_entry.data;
      end
    end
  end

  always_comb begin
    out_pending = '0;
    for (int unsigned i = 0; i < fifo_depth; i++) begin
      if (alu_valid_mask[i]) out_pending[alu_selects[i]] = 1'b1;
      if (mem_valid_mask[i]) out_pending[mem_selects[i]] = 1'b1;
    end
    if (out_write_enable) out_pending[out_write_register_select] = 1'b1;
    out_pending[0] = 1'b0;
  end

endmodule
